// File: rtl/jtag_tap.sv
// IEEE 1149.1 TAP controller with instruction register, BYPASS, IDCODE and one user DR.
// State and scan registers advance on rising TCK; TDO/TDO_EN are launched on falling TCK.
module jtag_tap #(
    parameter int unsigned     IR_W       = 4,
    parameter logic [31:0]     IDCODE_VAL = 32'h1000_0001,
    parameter logic [IR_W-1:0] IDCODE_OP  = 4'b0001,
    parameter logic [IR_W-1:0] USER_OP    = 4'b0010,
    parameter int unsigned     USER_W     = 8
) (
    input  logic              TCK,
    input  logic              TRST,
    input  logic              TMS,
    input  logic              TDI,
    output logic              TDO,
    output logic              TDO_EN,
    output logic [3:0]        state,
    output logic [IR_W-1:0]   ir,
    input  logic [USER_W-1:0] user_capture,
    output logic [USER_W-1:0] user_update,
    output logic              user_update_stb,
    output logic              test_logic_reset
);

    localparam int unsigned DR_W = (USER_W > 32) ? USER_W : 32;

    typedef enum logic [3:0] {
        TLR    = 4'h0, RTI    = 4'h1, SEL_DR = 4'h2, CAP_DR = 4'h3,
        SH_DR  = 4'h4, EX1_DR = 4'h5, PA_DR  = 4'h6, EX2_DR = 4'h7,
        UPD_DR = 4'h8, SEL_IR = 4'h9, CAP_IR = 4'hA, SH_IR  = 4'hB,
        EX1_IR = 4'hC, PA_IR  = 4'hD, EX2_IR = 4'hE, UPD_IR = 4'hF
    } tap_state_t;

    tap_state_t        state_q, state_d;
    logic [IR_W-1:0]   ir_sr_q, ir_sr_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [DR_W-1:0]   dr_q, dr_d;
    logic [USER_W-1:0] user_update_q, user_update_d;
    logic              stb_q, stb_d;
    logic              tdo_q, tdo_d;
    logic              tdo_en_q, tdo_en_d;
    logic              sel_idcode_s, sel_user_s;

    // IDCODE wins if both opcodes were ever configured identical; anything else is BYPASS.
    assign sel_idcode_s = (ir_q == IDCODE_OP);
    assign sel_user_s   = (ir_q == USER_OP) && !sel_idcode_s;

    // TAP state register.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    // TAP next-state decode from TMS.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    state_d = TMS ? TLR    : RTI;
            RTI:    state_d = TMS ? SEL_DR : RTI;
            SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
            SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
            EX1_DR: state_d = TMS ? UPD_DR : PA_DR;
            PA_DR:  state_d = TMS ? EX2_DR : PA_DR;
            EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
            UPD_DR: state_d = TMS ? SEL_DR : RTI;
            SEL_IR: state_d = TMS ? TLR    : CAP_IR;
            CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
            SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
            EX1_IR: state_d = TMS ? UPD_IR : PA_IR;
            PA_IR:  state_d = TMS ? EX2_IR : PA_IR;
            EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
            UPD_IR: state_d = TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Capture/shift/update behaviour of the IR, the shared DR and the user output.
    always_comb begin
        ir_sr_d       = ir_sr_q;
        ir_d          = ir_q;
        dr_d          = dr_q;
        user_update_d = user_update_q;
        stb_d         = 1'b0;
        case (state_q)
            TLR:    ir_d    = IDCODE_OP;
            CAP_IR: ir_sr_d = {{(IR_W-1){1'b0}}, 1'b1};
            SH_IR:  ir_sr_d = {TDI, ir_sr_q[IR_W-1:1]};
            UPD_IR: ir_d    = ir_sr_q;
            CAP_DR: begin
                if (sel_idcode_s) begin
                    dr_d = DR_W'(IDCODE_VAL);
                end else if (sel_user_s) begin
                    dr_d = DR_W'(user_capture);
                end else begin
                    dr_d = '0;
                end
            end
            SH_DR: begin
                // Bits above the active length carry don't-care data.
                dr_d = {1'b0, dr_q[DR_W-1:1]};
                if (sel_idcode_s) begin
                    dr_d[31] = TDI;
                end else if (sel_user_s) begin
                    dr_d[USER_W-1] = TDI;
                end else begin
                    dr_d[0] = TDI;
                end
            end
            UPD_DR: begin
                if (sel_user_s) begin
                    user_update_d = dr_q[USER_W-1:0];
                    stb_d         = 1'b1;
                end else begin
                    user_update_d = user_update_q;
                end
            end
            default: ir_d = ir_q;
        endcase
    end

    // Rising-edge scan and user registers.
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_sr_q       <= '0;
            ir_q          <= IDCODE_OP;
            dr_q          <= '0;
            user_update_q <= '0;
            stb_q         <= 1'b0;
        end else begin
            ir_sr_q       <= ir_sr_d;
            ir_q          <= ir_d;
            dr_q          <= dr_d;
            user_update_q <= user_update_d;
            stb_q         <= stb_d;
        end
    end

    // TDO source selection for the falling-edge launch.
    always_comb begin
        tdo_d    = 1'b0;
        tdo_en_d = 1'b0;
        if (state_q == SH_DR) begin
            tdo_d    = dr_q[0];
            tdo_en_d = 1'b1;
        end else if (state_q == SH_IR) begin
            tdo_d    = ir_sr_q[0];
            tdo_en_d = 1'b1;
        end else begin
            tdo_d    = 1'b0;
            tdo_en_d = 1'b0;
        end
    end

    // Falling-edge TDO launch.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign TDO              = tdo_q;
    assign TDO_EN           = tdo_en_q;
    assign state            = state_q;
    assign ir               = ir_q;
    assign user_update      = user_update_q;
    assign user_update_stb  = stb_q;
    assign test_logic_reset = (state_q == TLR);

endmodule

// File: tb/tb_jtag_tap.sv
// Self-checking bench for jtag_tap: table-driven TAP walk plus scoreboarded scans.
module tb_jtag_tap;

    logic       TCK = 1'b0;
    logic       TRST = 1'b0;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       TDO, TDO_EN, user_update_stb, test_logic_reset;
    logic [3:0] state, ir;
    logic [7:0] user_capture = 8'h00;
    logic [7:0] user_update;

    localparam logic [31:0] IDCODE = 32'h1000_0001;

    jtag_tap dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
        .state(state), .ir(ir), .user_capture(user_capture), .user_update(user_update),
        .user_update_stb(user_update_stb), .test_logic_reset(test_logic_reset)
    );

    always #5 TCK = ~TCK;

    typedef struct { logic tms; logic [3:0] st; logic en; } vec_t;
    typedef struct { int len; logic [7:0] tms; } path_t;

    vec_t   walk[$];
    path_t  paths[16];
    logic   exp_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     en_cnt = 0;
    int     stb_seen = 0;
    int     stb0;
    bit     sb_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One TCK cycle; returns 1ns after the falling edge. TDO is scoreboarded there.
    task automatic step(input logic tms, input logic tdi);
        logic e;
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
        if (user_update_stb) stb_seen++;
        @(negedge TCK);
        #1;
        if (TDO_EN) begin
            en_cnt++;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    check("tdo_unexpected", 64'(TDO_EN), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("tdo_bit", 64'(TDO), 64'(e));
                end
            end
        end
    endtask

    // Full IR or DR scan starting and ending in RTI.
    task automatic scan(input logic is_ir, input int n, input logic [63:0] tdi, input logic [63:0] exp);
        for (int i = 0; i < n; i++) exp_q.push_back(exp[i]);
        en_cnt = 0;
        sb_on  = 1'b1;
        step(1'b1, 1'b0);
        if (is_ir) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) step(i == n - 1, tdi[i]);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        sb_on = 1'b0;
        check(is_ir ? "ir_scan_len" : "dr_scan_len", 64'(en_cnt), 64'(n));
        check("sb_drain", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    task automatic wv(input logic tms, input logic [3:0] st);
        walk.push_back('{tms, st, (st == 4'h4) || (st == 4'hB)});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // TAP walk covering all 32 transitions, starting from TLR.
        wv(1,4'h0); wv(0,4'h1); wv(0,4'h1); wv(1,4'h2); wv(0,4'h3); wv(0,4'h4);
        wv(0,4'h4); wv(1,4'h5); wv(0,4'h6); wv(0,4'h6); wv(1,4'h7); wv(0,4'h4);
        wv(1,4'h5); wv(1,4'h8); wv(1,4'h2); wv(1,4'h9); wv(0,4'hA); wv(1,4'hC);
        wv(0,4'hD); wv(1,4'hE); wv(1,4'hF); wv(0,4'h1); wv(1,4'h2); wv(0,4'h3);
        wv(1,4'h5); wv(0,4'h6); wv(1,4'h7); wv(1,4'h8); wv(0,4'h1); wv(1,4'h2);
        wv(1,4'h9); wv(1,4'h0); wv(0,4'h1); wv(1,4'h2); wv(1,4'h9); wv(0,4'hA);
        wv(0,4'hB); wv(0,4'hB); wv(1,4'hC); wv(0,4'hD); wv(0,4'hD); wv(1,4'hE);
        wv(0,4'hB); wv(1,4'hC); wv(1,4'hF); wv(1,4'h2); wv(1,4'h9); wv(1,4'h0);

        // TMS paths from TLR to each state, applied LSB first.
        paths[0]  = '{0, 8'b0};        paths[1]  = '{1, 8'b0};
        paths[2]  = '{2, 8'b10};       paths[3]  = '{3, 8'b010};
        paths[4]  = '{4, 8'b0010};     paths[5]  = '{4, 8'b1010};
        paths[6]  = '{5, 8'b01010};    paths[7]  = '{6, 8'b101010};
        paths[8]  = '{5, 8'b11010};    paths[9]  = '{3, 8'b110};
        paths[10] = '{4, 8'b0110};     paths[11] = '{5, 8'b00110};
        paths[12] = '{5, 8'b10110};    paths[13] = '{6, 8'b010110};
        paths[14] = '{7, 8'b1010110};  paths[15] = '{6, 8'b110110};

        // Reset values while TRST is low.
        repeat (3) @(negedge TCK);
        #1;
        check("rst_state", 64'(state), 64'(0));
        check("rst_ir", 64'(ir), 64'(4'h1));
        check("rst_tdo", 64'(TDO), 64'(0));
        check("rst_tdo_en", 64'(TDO_EN), 64'(0));
        check("rst_user_update", 64'(user_update), 64'(0));
        check("rst_stb", 64'(user_update_stb), 64'(0));
        check("rst_tlr", 64'(test_logic_reset), 64'(1));
        TRST = 1'b1;

        foreach (walk[k]) begin
            step(walk[k].tms, 1'b0);
            check("walk_state", 64'(state), 64'(walk[k].st));
            check("walk_tdo_en", 64'(TDO_EN), 64'(walk[k].en));
            check("walk_tlr", 64'(test_logic_reset), 64'(walk[k].st == 4'h0));
        end
        check("walk_no_stb", 64'(stb_seen), 64'(0));

        // Five TMS=1 clocks reach TLR from every state.
        for (int s = 0; s < 16; s++) begin
            for (int b = 0; b < paths[s].len; b++) step(paths[s].tms[b], 1'b0);
            check("path_state", 64'(state), 64'(s));
            repeat (5) step(1'b1, 1'b0);
            check("tms5_state", 64'(state), 64'(0));
            check("tms5_tlr", 64'(test_logic_reset), 64'(1));
            step(1'b0, 1'b0);
            check("tlr_to_rti", 64'(state), 64'(1));
            repeat (3) step(1'b1, 1'b0);
        end
        check("tlr_ir_default", 64'(ir), 64'(4'h1));

        // IDCODE scan after reset.
        step(1'b0, 1'b0);
        scan(1'b0, 32, 64'(0), 64'(IDCODE));

        // IR all-ones selects BYPASS; one-cycle delay.
        scan(1'b1, 4, 64'(4'hF), 64'(4'b0001));
        check("ir_ones", 64'(ir), 64'(4'hF));
        scan(1'b0, 4, 64'(4'b1101), 64'(4'b1010));

        // USER scan with a pause/exit2 detour mid-shift.
        scan(1'b1, 4, 64'(4'b0010), 64'(4'b0001));
        check("ir_user", 64'(ir), 64'(4'h2));
        user_capture = 8'hA5;
        for (int i = 0; i < 8; i++) exp_q.push_back(user_capture[i]);
        en_cnt = 0;
        stb0 = stb_seen;
        sb_on = 1'b1;
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(i == 3, (8'h3C >> i) & 8'h01);
        step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
        check("detour_ex2", 64'(state), 64'(4'h7));
        step(1'b0, 1'b0);
        check("detour_back_sh", 64'(state), 64'(4'h4));
        for (int i = 4; i < 8; i++) step(i == 7, (8'h3C >> i) & 8'h01);
        step(1'b1, 1'b0);
        check("upd_pre_stb", 64'(user_update_stb), 64'(0));
        step(1'b0, 1'b0);
        check("user_update", 64'(user_update), 64'(8'h3C));
        check("user_stb_hi", 64'(user_update_stb), 64'(1));
        step(1'b0, 1'b0);
        check("user_stb_lo", 64'(user_update_stb), 64'(0));
        sb_on = 1'b0;
        check("user_scan_len", 64'(en_cnt), 64'(8));
        check("user_sb_drain", 64'(exp_q.size()), 64'(0));
        check("user_stb_count", 64'(stb_seen), 64'(stb0 + 1));
        exp_q.delete();

        // Undefined opcode behaves as BYPASS with no strobe.
        scan(1'b1, 4, 64'(4'h7), 64'(4'b0001));
        check("ir_invalid", 64'(ir), 64'(4'h7));
        stb0 = stb_seen;
        scan(1'b0, 4, 64'(4'b1011), 64'(4'b0110));
        check("bypass_no_stb", 64'(stb_seen), 64'(stb0));
        check("bypass_keep_update", 64'(user_update), 64'(8'h3C));

        // TRST mid USER shift abandons the scan.
        scan(1'b1, 4, 64'(4'b0010), 64'(4'b0001));
        user_capture = 8'h5A;
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        step(1'b0, 1'b1); step(1'b0, 1'b1);
        TRST = 1'b0;
        #2;
        check("trst_state", 64'(state), 64'(0));
        check("trst_ir", 64'(ir), 64'(4'h1));
        check("trst_tdo_en", 64'(TDO_EN), 64'(0));
        check("trst_user_update", 64'(user_update), 64'(0));
        @(negedge TCK);
        #1;
        TRST = 1'b1;
        stb0 = stb_seen;
        step(1'b0, 1'b0);
        scan(1'b0, 32, 64'(0), 64'(IDCODE));
        check("post_trst_no_stb", 64'(stb_seen), 64'(stb0));
        check("post_trst_update", 64'(user_update), 64'(0));
        scan(1'b1, 4, 64'(4'b0010), 64'(4'b0001));
        scan(1'b0, 8, 64'(8'hC3), 64'(8'h5A));
        check("post_trst_user", 64'(user_update), 64'(8'hC3));
        check("post_trst_stb", 64'(stb_seen), 64'(stb0 + 1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_tap.md
# jtag_tap

Parametrised IEEE 1149.1 TAP controller with an integrated instruction register, BYPASS, IDCODE and one user data register. It generalises the bare 16-state TAP state machine into a complete scan port that a chip-level JTAG wrapper instantiates directly. All logic runs on TCK; TDO is launched on the falling edge as the standard requires.

## Interface
- IR_W, 4: instruction register width in bits, minimum 2.
- IDCODE_VAL, 32'h1000_0001: IDCODE register contents; bit 0 must be 1.
- IDCODE_OP, 4'b0001: opcode selecting IDCODE; IR_W bits wide.
- USER_OP, 4'b0010: opcode selecting the user DR; IR_W bits wide.
- USER_W, 8: user data register width in bits, minimum 1.
- TCK  in  1  test clock; the single clock; both edges are used.
- TRST  in  1  reset, asynchronous and active-low.
- TMS  in  1  mode select, sampled on rising TCK.
- TDI  in  1  serial data in, sampled on rising TCK.
- TDO  out  1  serial data out, changes on falling TCK.
- TDO_EN  out  1  high while TDO carries valid shift data.
- state  out  4  current TAP state.
- ir  out  IR_W  active (updated) instruction.
- user_capture  in  USER_W  parallel value loaded in CAPTURE_DR when `ir == USER_OP`.
- user_update  out  USER_W  user DR value latched in UPDATE_DR.
- user_update_stb  out  1  one-TCK pulse when user_update is written.
- test_logic_reset  out  1  high while state is TEST_LOGIC_RESET.

## Operation
- State encoding:
  - TLR 0, RTI 1, SEL_DR 2, CAP_DR 3, SH_DR 4, EX1_DR 5, PA_DR 6, EX2_DR 7, UPD_DR 8.
  - SEL_IR 9, CAP_IR A, SH_IR B, EX1_IR C, PA_IR D, EX2_IR E, UPD_IR F.
- Transitions, written as state: TMS=0 target / TMS=1 target. DR and IR branches are symmetric.
  - TLR: RTI / TLR.
  - RTI: RTI / SEL_DR.
  - SEL_DR: CAP_DR / SEL_IR.
  - SEL_IR: CAP_IR / TLR.
  - CAP: SH / EX1.
  - SH: SH / EX1.
  - EX1: PA / UPD.
  - PA: PA / EX2.
  - EX2: SH / UPD. EX2 with TMS=0 returns to SHIFT and never holds.
  - UPD: RTI / SEL_DR.
- Instruction decode: `ir == IDCODE_OP` selects IDCODE; `ir == USER_OP` selects USER. Every other opcode, including all-ones, selects BYPASS.
- IR shift register, IR_W bits:
  - CAP_IR loads {0…0,0,1}, so bit0=1 and bit1=0.
  - SH_IR shifts right: TDI enters the MSB and the LSB goes to TDO.
  - UPD_IR copies the shift register into `ir` on the rising edge taken while in UPD_IR.
- DR shift register:
  - One shared register, max(32, USER_W) bits wide; the active length depends on the instruction (32, USER_W or 1).
  - CAP_DR loads IDCODE_VAL, user_capture, or 0 for BYPASS.
  - SH_DR shifts right: TDI enters bit (len-1) and bit0 goes to TDO.
- User update: on the rising edge taken in UPD_DR with USER selected, user_update takes DR[USER_W-1:0] and user_update_stb is 1 for exactly that next cycle. UPD_DR under any other instruction produces no strobe.
- TLR is entered by TRST low or by the FSM. While in TLR, `ir` is forced to IDCODE_OP on every rising edge, so IDCODE is the default instruction.
- Reset values while TRST is low:
  - state=TLR, ir=IDCODE_OP.
  - IR and DR shift registers 0.
  - TDO=0, TDO_EN=0.
  - user_update=0, user_update_stb=0, test_logic_reset=1.
- TRST assertion mid-shift abandons the scan immediately: no update occurs and user_update keeps its pre-reset clear value 0.

## Timing
- state, the shift registers, ir, user_update and user_update_stb update on rising TCK.
- TDO and TDO_EN update on falling TCK.
  - In SH_DR or SH_IR, TDO is bit0 of the corresponding shift register and TDO_EN=1.
  - Otherwise TDO=0 and TDO_EN=0.
- The first TDO bit of a scan is valid on the falling edge after the rising edge that entered SH_*, which is the captured bit0.
- BYPASS adds exactly one TCK of TDI→TDO delay.
- Five rising edges with TMS=1 reach TLR from any state.
- test_logic_reset is decoded combinationally from state.
- TRST is asynchronous; deassertion is assumed to be clean relative to TCK. Synchronising TRST is the integrator's responsibility.

## Test plan
- TRST pulse low mid-SH_DR -> state=0, ir=IDCODE_OP, TDO_EN=0, user_update=0; the next update pulses nothing until a full USER scan completes.
- From each of the 16 states, 5 TCKs with TMS=1 -> state=0 and test_logic_reset=1; then TMS=0 -> state=1.
- After reset, path TLR→RTI→SEL_DR→CAP_DR and 32 SH_DR clocks -> TDO serially emits 0x10000001 LSB-first, with TDO_EN high for exactly 32 falling edges.
- IR scan shifting in 4'b1111 -> TDO emits 1,0,0,0 during SH_IR and ir=4'hF after UPD_IR. A following DR scan with TDI=1,0,1,1 -> TDO=0,1,0,1 (one-cycle bypass delay).
- Load USER_OP, user_capture=8'hA5, shift in 8'h3C with a PA_DR/EX2_DR→SH_DR detour mid-scan:
  - TDO emits A5 LSB-first.
  - user_update=8'h3C.
  - user_update_stb is high for one cycle.
- Invalid opcode 4'h7 -> behaves as BYPASS (1-bit DR, capture 0) and UPD_DR produces no user_update_stb.
